stopwatch_ctrl: RTL and testbench

//  Control FSM for the stopwatch datapath (centisecond/second/minute/hour counters, BCD, display scan).

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/stopwatch_if.sv | 20 ++
 rtl/press_detect.sv | 21 ++
 rtl/stopwatch_ctrl.sv | 115 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control block: state codes and defaults.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_e;

  localparam int DEF_TICK_HZ = 100;

  // True in the states where the counter chain advances.
  function automatic logic is_counting(input state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Button-in / control-out bundle between the stopwatch controller and its neighbours.
interface stopwatch_if;
  logic       btn_ss;       // debounced start/stop level
  logic       btn_lap;      // debounced lap/clear level
  logic       tick_en;      // 100 Hz count enable
  logic       cnt_clr;      // counter chain clear
  logic       lap_cap;      // lap register capture
  logic       disp_frozen;  // display shows lap register
  logic [1:0] state;        // current state code

  modport master (
    output btn_ss, btn_lap,
    input  tick_en, cnt_clr, lap_cap, disp_frozen, state
  );

  modport slave (
    input  btn_ss, btn_lap,
    output tick_en, cnt_clr, lap_cap, disp_frozen, state
  );
endinterface

// File: rtl/press_detect.sv
// Rising-edge detector for a debounced button level. The history register
// resets to 1 so a button already held when reset releases is not a press.
module press_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  logic r_prev;

  // Track the previous button level.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b1;
    else     r_prev <= i_btn;
  end

  assign o_press = i_btn & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop, lap capture, clear-by-long-press while
// paused, plus the free-running prescaler that makes the count enable.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = DEF_TICK_HZ,
  parameter int LONG_TICKS = 200
) (
  input  logic         clk,
  input  logic         rst,
  stopwatch_if.slave   bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW  = $clog2(LONG_TICKS + 1);

  logic          w_ss_press;
  logic          w_lap_press;
  logic          w_wrap;
  logic          w_reload;
  logic          w_long_done;
  logic          w_lap_cap;
  state_e        w_state_nxt;

  state_e        r_state;
  logic [PW-1:0] r_presc;
  logic [HW-1:0] r_hold;
  logic          r_tick_en;
  logic          r_cnt_clr;
  logic          r_lap_cap;
  logic          r_disp_frozen;

  press_detect u_ss_press (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (bus.btn_ss),
    .o_press (w_ss_press)
  );

  press_detect u_lap_press (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (bus.btn_lap),
    .o_press (w_lap_press)
  );

  assign w_wrap   = (r_presc == PW'(DIV - 1));
  assign w_reload = (r_state == ST_IDLE) && w_ss_press;
  // Start/stop always takes priority, so a coincident lap press is dropped.
  assign w_lap_cap = is_counting(r_state) && w_lap_press && !w_ss_press;

  // Next-state decision; start/stop beats lap and beats long-press completion.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_long_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_press) w_state_nxt = ST_RUN;
      end
      ST_RUN, ST_LAP: begin
        if (w_ss_press)       w_state_nxt = ST_PAUSE;
        else if (w_lap_press) w_state_nxt = ST_LAP;
      end
      ST_PAUSE: begin
        if (w_ss_press) begin
          w_state_nxt = ST_RUN;
        end else if (w_wrap && bus.btn_lap && (r_hold == HW'(LONG_TICKS - 1))) begin
          w_state_nxt = ST_IDLE;
          w_long_done = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, prescaler, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_presc       <= '0;
      r_hold        <= '0;
      r_tick_en     <= 1'b0;
      r_cnt_clr     <= 1'b0;
      r_lap_cap     <= 1'b0;
      r_disp_frozen <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // Restart the centisecond phase only on a fresh start from IDLE.
      if (w_reload || w_wrap) r_presc <= '0;
      else                    r_presc <= r_presc + 1'b1;

      r_tick_en     <= w_wrap && !w_reload && is_counting(w_state_nxt);
      r_cnt_clr     <= w_long_done;
      r_lap_cap     <= w_lap_cap;
      r_disp_frozen <= (w_state_nxt == ST_LAP);

      // Count consecutive wraps with lap held while paused; any break restarts it.
      if ((w_state_nxt != ST_PAUSE) || !bus.btn_lap)
        r_hold <= '0;
      else if (w_wrap && (r_state == ST_PAUSE) && (r_hold < HW'(LONG_TICKS)))
        r_hold <= r_hold + 1'b1;
    end
  end

  assign bus.tick_en     = r_tick_en;
  assign bus.cnt_clr     = r_cnt_clr;
  assign bus.lap_cap     = r_lap_cap;
  assign bus.disp_frozen = r_disp_frozen;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 10-cycle prescaler and a 3-tick long press.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ     = 1000;
  localparam int TICK_HZ    = 100;
  localparam int LONG_TICKS = 3;
  localparam int DIV        = CLK_HZ / TICK_HZ;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stopwatch_if sw_if ();

  stopwatch_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .TICK_HZ    (TICK_HZ),
    .LONG_TICKS (LONG_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_tick  = 0;
  int n_cap   = 0;
  int n_clr   = 0;
  int cyc     = 0;
  int c0      = 0;   // edge count at the last IDLE->RUN transition (prescaler reload)

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters plus the never-together / never-outside-counting rules.
  always @(negedge clk) begin
    if (sw_if.tick_en) begin
      n_tick++;
      check("tick_only_run_lap", 32'(sw_if.state[0]), 32'd1);
    end
    if (sw_if.lap_cap) begin
      n_cap++;
      check("cap_without_clr", 32'(sw_if.cnt_clr), 32'd0);
    end
    if (sw_if.cnt_clr) n_clr++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_ss();
    sw_if.btn_ss = 1'b1;
    cycles(1);
    sw_if.btn_ss = 1'b0;
  endtask

  task automatic press_lap();
    sw_if.btn_lap = 1'b1;
    cycles(1);
    sw_if.btn_lap = 1'b0;
  endtask

  // Advance until the prescaler value just after the last edge equals k.
  task automatic wait_phase(input int k);
    for (int i = 0; i < DIV && (((cyc - c0) % DIV) != k); i++) cycles(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"},  32'(sw_if.state),       32'd0);
    check({tag, "_tick"},   32'(sw_if.tick_en),     32'd0);
    check({tag, "_clr"},    32'(sw_if.cnt_clr),     32'd0);
    check({tag, "_cap"},    32'(sw_if.lap_cap),     32'd0);
    check({tag, "_frozen"}, 32'(sw_if.disp_frozen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sw_if.btn_ss  = 1'b0;
    sw_if.btn_lap = 1'b0;

    // 1: reset, idle, lap press ignored
    cycles(3);
    check_all_zero("reset");
    rst = 1'b0;
    n_tick = 0; n_cap = 0; n_clr = 0;
    cycles(50);
    press_lap();
    cycles(5);
    check("idle_lap_state", 32'(sw_if.state), 32'd0);
    check("idle_no_tick",   32'(n_tick),      32'd0);
    check("idle_no_cap",    32'(n_cap),       32'd0);

    // 2: start, tick cadence, stop
    press_ss();
    c0 = cyc;
    check("start_state", 32'(sw_if.state), 32'd1);
    cycles(DIV - 1);
    check("first_tick_not_early", 32'(sw_if.tick_en), 32'd0);
    check("no_tick_before_first", 32'(n_tick),        32'd0);
    cycles(1);
    check("first_tick_at_div", 32'(sw_if.tick_en), 32'd1);
    cycles(1);
    check("tick_one_cycle", 32'(sw_if.tick_en), 32'd0);
    n_tick = 0;
    cycles(30);
    check("tick_every_div", 32'(n_tick), 32'd3);
    press_ss();
    check("stop_state", 32'(sw_if.state), 32'd2);
    n_tick = 0;
    cycles(40);
    check("pause_no_tick", 32'(n_tick), 32'd0);

    // resume keeps prescaler phase: resume at phase 5, next tick 5 edges later
    wait_phase(4);
    press_ss();
    check("resume_state", 32'(sw_if.state), 32'd1);
    cycles(4);
    check("resume_tick_not_early", 32'(sw_if.tick_en), 32'd0);
    cycles(1);
    check("resume_tick_kept_phase", 32'(sw_if.tick_en), 32'd1);

    // 3: lap captures
    n_cap = 0;
    press_lap();
    check("lap_state",  32'(sw_if.state),       32'd3);
    check("lap_cap",    32'(sw_if.lap_cap),     32'd1);
    check("lap_frozen", 32'(sw_if.disp_frozen), 32'd1);
    cycles(1);
    check("lap_cap_one_cycle", 32'(sw_if.lap_cap), 32'd0);
    n_tick = 0;
    cycles(20);
    check("lap_ticks_continue", 32'(n_tick), 32'd2);
    press_lap();
    check("lap2_state", 32'(sw_if.state),   32'd3);
    check("lap2_cap",   32'(sw_if.lap_cap), 32'd1);
    cycles(2);
    check("lap_cap_count", 32'(n_cap), 32'd2);
    press_ss();
    check("lap_stop_state",  32'(sw_if.state),       32'd2);
    check("lap_stop_frozen", 32'(sw_if.disp_frozen), 32'd0);

    // 4: long press in PAUSE
    n_clr = 0;
    wait_phase(0);
    sw_if.btn_lap = 1'b1;
    cycles(25);                       // two wraps only
    sw_if.btn_lap = 1'b0;
    check("short_hold_no_clr", 32'(n_clr),       32'd0);
    check("short_hold_state",  32'(sw_if.state), 32'd2);
    cycles(3);
    wait_phase(0);
    sw_if.btn_lap = 1'b1;
    cycles(29);
    check("hold_before_third_wrap_clr",   32'(sw_if.cnt_clr), 32'd0);
    check("hold_before_third_wrap_state", 32'(sw_if.state),   32'd2);
    cycles(1);
    check("long_hold_clr",   32'(sw_if.cnt_clr), 32'd1);
    check("long_hold_state", 32'(sw_if.state),   32'd0);
    cycles(15);
    check("single_clr_while_held", 32'(n_clr),       32'd1);
    check("held_stays_idle",       32'(sw_if.state), 32'd0);
    sw_if.btn_lap = 1'b0;
    cycles(2);

    // 5: simultaneous ss+lap in RUN
    press_ss();
    c0 = cyc;
    check("restart_state", 32'(sw_if.state), 32'd1);
    cycles(3);
    n_cap = 0;
    sw_if.btn_ss  = 1'b1;
    sw_if.btn_lap = 1'b1;
    cycles(1);
    check("both_state", 32'(sw_if.state),   32'd2);
    check("both_cap",   32'(sw_if.lap_cap), 32'd0);
    sw_if.btn_ss  = 1'b0;
    sw_if.btn_lap = 1'b0;
    cycles(3);
    check("both_no_cap", 32'(n_cap), 32'd0);

    // long-press completion coinciding with ss press: ss wins
    n_clr = 0;
    wait_phase(0);
    sw_if.btn_lap = 1'b1;
    cycles(29);
    sw_if.btn_ss = 1'b1;
    cycles(1);
    check("ss_beats_long_state", 32'(sw_if.state),   32'd1);
    check("ss_beats_long_clr",   32'(sw_if.cnt_clr), 32'd0);
    sw_if.btn_ss  = 1'b0;
    sw_if.btn_lap = 1'b0;
    cycles(2);
    check("ss_beats_long_no_clr", 32'(n_clr), 32'd0);

    // ss held across reset release is not a press
    sw_if.btn_ss = 1'b1;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(3);
    check("held_through_rst_state", 32'(sw_if.state), 32'd0);
    sw_if.btn_ss = 1'b0;
    cycles(2);
    check("held_release_state", 32'(sw_if.state), 32'd0);

    // 6: reset in LAP mid-count
    press_ss();
    c0 = cyc;
    press_lap();
    check("pre_rst_lap_state", 32'(sw_if.state), 32'd3);
    cycles(4);
    rst = 1'b1;
    cycles(1);
    check_all_zero("mid_rst");
    cycles(1);
    rst = 1'b0;
    n_tick = 0;
    cycles(25);
    check("post_rst_no_tick", 32'(n_tick),      32'd0);
    check("post_rst_state",   32'(sw_if.state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
